// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N request channels in, one registered beat out.
// in_last/out_last are present only when RR_ARB_MUX_LOCK_EN is defined.
interface rr_arb_mux_if #(
    parameter int SIZE     = 4,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
);
    logic [CHANNELS*SIZE-1:0] in_data;
    logic [CHANNELS-1:0]      in_valid;
    logic [CHANNELS-1:0]      in_ready;
    logic [SIZE-1:0]          out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [SELW-1:0]          out_select;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [CHANNELS-1:0]      in_last;
    logic                     out_last;

    modport master (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_select, out_last
    );
    modport slave (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_select, out_last
    );
`else
    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_select
    );
    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_select
    );
`endif
endinterface

// File: rtl/rr_arb_mux.sv
// N:1 registered mux with fixed-priority (MODE=0) or round-robin (MODE=1) grant.
// Define RR_ARB_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_arb_mux #(
    parameter int SIZE     = 4,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2,
    parameter int MODE     = 1
) (
    input logic           clk,
    input logic           reset_n,
    rr_arb_mux_if.master  bus
);
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] next_ptr;
    logic            any;
    logic            load;
    logic [SIZE-1:0] sel_data;

    logic [SIZE-1:0] data_p1;
    logic [SELW-1:0] select_p1;
    logic            vld_p1;
`ifdef RR_ARB_MUX_LOCK_EN
    logic            last_p1;
    logic            locked;
    logic [SELW-1:0] lock_ch;
`endif

    assign load = !vld_p1 || bus.out_ready;

    // Scan starts at ptr in round-robin mode, at channel 0 in fixed-priority mode.
    always_comb begin
        int idx;
        logic [SELW-1:0] idx_s;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        idx_s = '0;
`ifdef RR_ARB_MUX_LOCK_EN
        if (locked) begin
            grant = lock_ch;
            any   = bus.in_valid[lock_ch];
        end else begin
`else
        begin
`endif
            for (int k = 0; k < CHANNELS; k++) begin
                idx = (MODE == 1) ? int'(ptr) + k : k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                idx_s = SELW'(idx);
                if (!any && bus.in_valid[idx_s]) begin
                    any   = 1'b1;
                    grant = idx_s;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SELW'(i)) sel_data = bus.in_data[i*SIZE +: SIZE];
        end
    end

    assign next_ptr     = (grant == SELW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
    assign bus.in_ready = (reset_n && load && any) ? (CHANNELS'(1) << grant) : '0;

    // p0 -> p1: output register; a retiring beat and a new load share the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            select_p1 <= '0;
            ptr       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            last_p1   <= 1'b0;
            locked    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load) begin
            vld_p1 <= any;
            if (any) begin
                data_p1   <= sel_data;
                select_p1 <= grant;
`ifdef RR_ARB_MUX_LOCK_EN
                last_p1   <= bus.in_last[grant];
                locked    <= !bus.in_last[grant];
                lock_ch   <= grant;
                if (MODE == 1 && bus.in_last[grant]) ptr <= next_ptr;
`else
                if (MODE == 1) ptr <= next_ptr;
`endif
            end
        end
    end

    assign bus.out_data   = data_p1;
    assign bus.out_select = select_p1;
    assign bus.out_valid  = vld_p1;
`ifdef RR_ARB_MUX_LOCK_EN
    assign bus.out_last   = last_p1;
`endif
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin instance and one fixed-priority instance.
module tb_rr_arb_mux;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.SIZE(4), .CHANNELS(4), .SELW(2)) b1 ();
    rr_arb_mux_if #(.SIZE(4), .CHANNELS(4), .SELW(2)) b0 ();

    rr_arb_mux #(.SIZE(4), .CHANNELS(4), .SELW(2), .MODE(1)) dut_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1.master)
    );

    rr_arb_mux #(.SIZE(4), .CHANNELS(4), .SELW(2), .MODE(0)) dut_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_sel  [5];
        logic [3:0] rr_data [5];
        rr_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data = '{4'h3, 4'hC, 4'hA, 4'h5, 4'h3};

        reset_n      = 1'b0;
        b1.in_data   = 16'h5AC3;
        b1.in_valid  = 4'b1111;
        b1.out_ready = 1'b1;
        b0.in_data   = 16'h5AC3;
        b0.in_valid  = 4'b1111;
        b0.out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        b1.in_last   = 4'b1111;
        b0.in_last   = 4'b1111;
`endif

        // reset held for two edges with every channel requesting
        tick();
        tick();
        chk("rst_in_ready", b1.in_ready, 4'b0000);
        chk("rst_out_valid", b1.out_valid, 1'b0);
        chk("rst_out_data", b1.out_data, 4'h0);
        chk("rst_out_select", b1.out_select, 2'd0);
        chk("rst_fp_in_ready", b0.in_ready, 4'b0000);
        chk("rst_fp_out_valid", b0.out_valid, 1'b0);

        reset_n     = 1'b1;
        b0.in_valid = 4'b0000;
        #1;
        chk("rr_first_ready", b1.in_ready, 4'b0001);

        // round-robin rotation over all four channels
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_valid", b1.out_valid, 1'b1);
            chk("rr_select", b1.out_select, rr_sel[i]);
            chk("rr_data", b1.out_data, rr_data[i]);
        end

        // stall with channel 1 (4'hC) held in the output register
        tick();
        chk("stall_load_data", b1.out_data, 4'hC);
        b1.out_ready = 1'b0;
        #1;
        chk("stall_ready", b1.in_ready, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", b1.out_data, 4'hC);
            chk("stall_select", b1.out_select, 2'd1);
            chk("stall_valid", b1.out_valid, 1'b1);
            chk("stall_in_ready", b1.in_ready, 4'b0000);
        end
        b1.out_ready = 1'b1;
        #1;
        chk("release_ready", b1.in_ready, 4'b0100);
        tick();
        chk("release_select", b1.out_select, 2'd2);
        chk("release_data", b1.out_data, 4'hA);

        // wrap from channel 3 back to 0, then idle
        chk("wrap_ready", b1.in_ready, 4'b1000);
        tick();
        chk("wrap_select", b1.out_select, 2'd3);
        chk("wrap_data", b1.out_data, 4'h5);
        b1.in_valid = 4'b0000;
        #1;
        chk("idle_ready", b1.in_ready, 4'b0000);
        tick();
        chk("idle_valid1", b1.out_valid, 1'b0);
        chk("idle_hold_data", b1.out_data, 4'h5);
        chk("idle_hold_select", b1.out_select, 2'd3);
        tick();
        chk("idle_valid2", b1.out_valid, 1'b0);
        b1.in_valid = 4'b0110;
        #1;
        chk("after_idle_ready", b1.in_ready, 4'b0010);
        tick();
        chk("after_idle_select", b1.out_select, 2'd1);
        chk("after_idle_data", b1.out_data, 4'hC);
        chk("after_idle_next", b1.in_ready, 4'b0100);

`ifdef RR_ARB_MUX_LOCK_EN
        // channel 2 burst of three beats while 0 and 1 keep requesting
        b1.in_valid = 4'b0111;
        b1.in_last  = 4'b0000;
        #1;
        chk("lock_first_ready", b1.in_ready, 4'b0100);
        tick();
        chk("lock_b1_select", b1.out_select, 2'd2);
        chk("lock_b1_last", b1.out_last, 1'b0);
        chk("lock_hold_ready", b1.in_ready, 4'b0100);
        b1.in_valid = 4'b0011;
        #1;
        chk("lock_gap_ready", b1.in_ready, 4'b0000);
        tick();
        chk("lock_gap_valid", b1.out_valid, 1'b0);
        b1.in_valid = 4'b0111;
        #1;
        tick();
        chk("lock_b2_select", b1.out_select, 2'd2);
        chk("lock_b2_last", b1.out_last, 1'b0);
        b1.in_last = 4'b0100;
        #1;
        tick();
        chk("lock_b3_select", b1.out_select, 2'd2);
        chk("lock_b3_last", b1.out_last, 1'b1);
        chk("unlock_ready", b1.in_ready, 4'b0001);
        tick();
        chk("unlock_select", b1.out_select, 2'd0);
        chk("unlock_data", b1.out_data, 4'h3);
`endif

        // fixed priority: lowest requesting index wins every beat
        b0.in_valid = 4'b1010;
        #1;
        chk("fp_ready", b0.in_ready, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fp_select", b0.out_select, 2'd1);
            chk("fp_data", b0.out_data, 4'hC);
        end
        b0.in_valid = 4'b1000;
        #1;
        chk("fp_ch3_ready", b0.in_ready, 4'b1000);
        tick();
        chk("fp_ch3_select", b0.out_select, 2'd3);
        chk("fp_ch3_data", b0.out_data, 4'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
